// File: rtl/barrier_gen_if.sv
// barrier_gen_if: scroll-rate/crash inputs and field outputs of the barrier generator
interface barrier_gen_if;
  logic tick;
  logic crash;
  logic [7:0][7:0] grid;
  logic [7:0] barrier;
  logic spawn;
  modport master (output tick, crash, input grid, barrier, spawn);
  modport slave (input tick, crash, output grid, barrier, spawn);
endinterface

// File: rtl/barrier_gen.sv
// barrier_gen: scrolling barrier field with random gaps for the 8x8 LED array
module barrier_gen #(
  parameter int SCROLL_DIV = 4,
  parameter int SPACING = 4,
  parameter int GAP_W = 3,
  parameter logic [7:0] SEED = 8'hA5
) (
  input logic clk,
  input logic reset,
  barrier_gen_if.slave bus
);
  localparam int DW = SCROLL_DIV > 1 ? $clog2(SCROLL_DIV) : 1;
  localparam int SW = $clog2(SPACING);
  localparam int HI = 8 - GAP_W;
  logic [DW-1:0] div_cnt;
  logic [SW-1:0] space_cnt;
  logic [7:0] lfsr;
  logic [7:0][7:0] grid;
  logic spawn;
  logic adv, last, step, ins;
  logic [2:0] p_sub, p;
  logic [7:0] row;
  always_comb begin
    adv = bus.tick & ~bus.crash;
    last = div_cnt == DW'(SCROLL_DIV - 1);
    step = adv & last;
    ins = space_cnt == SW'(SPACING - 1);
    p_sub = lfsr[2:0] - 3'(9 - GAP_W);
    // wide gaps can overshoot after one fold; those land on the left edge
    p = lfsr[2:0] > 3'(HI) ? (p_sub > 3'(HI) ? 3'd0 : p_sub) : lfsr[2:0];
    row = ~(8'((1 << GAP_W) - 1) << p);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      space_cnt <= '0;
      lfsr <= SEED;
      grid <= '0;
      spawn <= 1'b0;
    end else begin
      spawn <= 1'b0;
      if (adv) div_cnt <= last ? '0 : div_cnt + 1'b1;
      if (step) begin
        grid <= {grid[6:0], ins ? row : 8'h00};
        space_cnt <= ins ? '0 : space_cnt + 1'b1;
        spawn <= ins;
        if (ins) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
    end
  end
  assign bus.grid = grid;
  assign bus.barrier = grid[7];
  assign bus.spawn = spawn;
endmodule

// File: tb/tb_barrier_gen.sv
// tb_barrier_gen: directed scenarios plus randomized run against a tick-counting model
module tb_barrier_gen;
  logic clk = 0, reset = 0, tick = 0, crash = 0;
  int n_cmp = 0, n_bad = 0;
  int m_ticks, m_steps;
  logic [7:0] m_lfsr;
  logic [7:0][7:0] m_grid;
  logic m_spawn;
  barrier_gen_if bi ();
  barrier_gen_if b6a ();
  barrier_gen_if b6b ();
  assign bi.tick = tick;
  assign bi.crash = crash;
  assign b6a.tick = tick;
  assign b6a.crash = crash;
  assign b6b.tick = tick;
  assign b6b.crash = crash;
  barrier_gen u_dut (.clk(clk), .reset(reset), .bus(bi));
  barrier_gen #(.GAP_W(6), .SEED(8'h07)) u_g6a (.clk(clk), .reset(reset), .bus(b6a));
  barrier_gen #(.GAP_W(6), .SEED(8'h02)) u_g6b (.clk(clk), .reset(reset), .bus(b6b));
  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [7:0] row_of(input logic [7:0] l, input int gw);
    int p;
    logic [7:0] r;
    p = int'(l[2:0]);
    if (p > 8 - gw) p -= 9 - gw;
    if (p > 8 - gw) p = 0;
    for (int b = 0; b < 8; b++) r[b] = (b < p) || (b >= p + gw);
    return r;
  endfunction

  // one clock: drive inputs, let the edge happen, advance the model, land on the negedge
  task automatic cyc(input logic t, input logic c, input logic r);
    tick = t;
    crash = c;
    reset = r;
    @(posedge clk);
    if (r) begin
      m_ticks = 0;
      m_steps = 0;
      m_lfsr = 8'hA5;
      m_grid = '0;
      m_spawn = 0;
    end else begin
      m_spawn = 0;
      if (t && !c) begin
        m_ticks++;
        if (m_ticks % 4 == 0) begin
          m_steps++;
          for (int i = 7; i > 0; i--) m_grid[i] = m_grid[i-1];
          m_grid[0] = 8'h00;
          if (m_steps % 4 == 0) begin
            m_grid[0] = row_of(m_lfsr, 3);
            m_lfsr = lfsr_next(m_lfsr);
            m_spawn = 1;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    n_cmp += 5;
    if (bi.grid !== '0) begin n_bad++; $display("FAIL reset_grid: got %h want 0", bi.grid); end
    if (bi.barrier !== 8'h00) begin n_bad++; $display("FAIL reset_barrier: got %h want 00", bi.barrier); end
    if (bi.spawn !== 1'b0) begin n_bad++; $display("FAIL reset_spawn: got %b want 0", bi.spawn); end
    if (u_dut.lfsr !== 8'hA5) begin n_bad++; $display("FAIL reset_lfsr: got %h want a5", u_dut.lfsr); end
    if (b6a.grid !== '0) begin n_bad++; $display("FAIL reset_grid6: got %h want 0", b6a.grid); end
  endtask

  task automatic test_first_barrier;
    int spawns = 0;
    cyc(0, 0, 1);
    for (int n = 1; n <= 60; n++) begin
      cyc(1, 0, 0);
      if (bi.spawn === 1'b1) spawns++;
      if (n == 16) begin
        n_cmp += 3;
        if (spawns !== 1) begin n_bad++; $display("FAIL first_spawn_count: got %0d want 1", spawns); end
        if (bi.spawn !== 1'b1) begin n_bad++; $display("FAIL first_spawn: got %b want 1", bi.spawn); end
        if (bi.grid[0] !== 8'b00011111) begin n_bad++; $display("FAIL first_row: got %b want 00011111", bi.grid[0]); end
      end
      if (n == 32) begin
        n_cmp += 2;
        if (bi.spawn !== 1'b1) begin n_bad++; $display("FAIL second_spawn: got %b want 1", bi.spawn); end
        if (bi.grid[0] !== 8'b11100011) begin n_bad++; $display("FAIL second_row: got %b want 11100011", bi.grid[0]); end
      end
      if (n == 43 || n == 48) begin
        n_cmp++;
        if (bi.barrier !== 8'h00) begin n_bad++; $display("FAIL bottom_blank@%0d: got %b want 00000000", n, bi.barrier); end
      end
      if (n >= 44 && n <= 47) begin
        n_cmp++;
        if (bi.barrier !== 8'b00011111) begin n_bad++; $display("FAIL bottom_dwell@%0d: got %b want 00011111", n, bi.barrier); end
      end
      if (n == 60) begin
        n_cmp += 2;
        if (bi.barrier !== 8'b11100011) begin n_bad++; $display("FAIL bottom_second: got %b want 11100011", bi.barrier); end
        if (spawns !== 3) begin n_bad++; $display("FAIL spawn_total: got %0d want 3", spawns); end
      end
    end
  endtask

  task automatic test_crash;
    logic [7:0][7:0] e;
    e = '0;
    e[3] = 8'b00011111;
    cyc(0, 0, 1);
    for (int n = 0; n < 30; n++) cyc(1, 0, 0);
    for (int n = 0; n < 20; n++) begin
      cyc(1, 1, 0);
      n_cmp += 2;
      if (bi.grid !== e) begin n_bad++; $display("FAIL crash_hold@%0d: got %h want %h", n, bi.grid, e); end
      if (bi.spawn !== 1'b0) begin n_bad++; $display("FAIL crash_spawn@%0d: got %b want 0", n, bi.spawn); end
    end
    cyc(1, 0, 0);
    n_cmp++;
    if (bi.grid !== e) begin n_bad++; $display("FAIL resume_early: got %h want %h", bi.grid, e); end
    cyc(1, 0, 0);
    e = {e[6:0], 8'b11100011};
    n_cmp += 2;
    if (bi.grid !== e) begin n_bad++; $display("FAIL resume_grid: got %h want %h", bi.grid, e); end
    if (bi.spawn !== 1'b1) begin n_bad++; $display("FAIL resume_spawn: got %b want 1", bi.spawn); end
    // final tick of a scroll period coincides with crash: no step
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    n_cmp++;
    if (bi.grid !== e) begin n_bad++; $display("FAIL crash_last_tick: got %h want %h", bi.grid, e); end
    cyc(1, 0, 0);
    n_cmp++;
    if (bi.grid !== {e[6:0], 8'h00}) begin n_bad++; $display("FAIL crash_last_resume: got %h want %h", bi.grid, {e[6:0], 8'h00}); end
  endtask

  task automatic test_gap_wrap;
    cyc(0, 0, 1);
    for (int n = 0; n < 16; n++) cyc(1, 0, 0);
    n_cmp += 4;
    if (b6a.grid[0] !== 8'b11000000) begin n_bad++; $display("FAIL gap_wrap_p0: got %b want 11000000", b6a.grid[0]); end
    if (b6b.grid[0] !== 8'b00000011) begin n_bad++; $display("FAIL gap_p2: got %b want 00000011", b6b.grid[0]); end
    if (b6a.spawn !== 1'b1) begin n_bad++; $display("FAIL gap_spawn_a: got %b want 1", b6a.spawn); end
    if (b6b.spawn !== 1'b1) begin n_bad++; $display("FAIL gap_spawn_b: got %b want 1", b6b.spawn); end
    for (int n = 0; n < 16; n++) cyc(1, 0, 0);
    n_cmp += 2;
    if (b6a.grid[0] !== row_of(lfsr_next(8'h07), 6)) begin n_bad++; $display("FAIL gap_second_a: got %b want %b", b6a.grid[0], row_of(lfsr_next(8'h07), 6)); end
    if (b6b.grid[0] !== row_of(lfsr_next(8'h02), 6)) begin n_bad++; $display("FAIL gap_second_b: got %b want %b", b6b.grid[0], row_of(lfsr_next(8'h02), 6)); end
  endtask

  task automatic test_reset_mid;
    cyc(0, 0, 1);
    for (int n = 0; n < 32; n++) cyc(1, 0, 0);
    n_cmp++;
    if (bi.grid[4] !== 8'b00011111) begin n_bad++; $display("FAIL mid_setup: got %b want 00011111", bi.grid[4]); end
    cyc(1, 1, 1);
    n_cmp += 3;
    if (bi.grid !== '0) begin n_bad++; $display("FAIL mid_grid: got %h want 0", bi.grid); end
    if (bi.barrier !== 8'h00) begin n_bad++; $display("FAIL mid_barrier: got %h want 00", bi.barrier); end
    if (bi.spawn !== 1'b0) begin n_bad++; $display("FAIL mid_spawn: got %b want 0", bi.spawn); end
    for (int n = 0; n < 16; n++) cyc(1, 0, 0);
    n_cmp += 2;
    if (bi.grid[0] !== 8'b00011111) begin n_bad++; $display("FAIL mid_restart_row: got %b want 00011111", bi.grid[0]); end
    if (bi.spawn !== 1'b1) begin n_bad++; $display("FAIL mid_restart_spawn: got %b want 1", bi.spawn); end
  endtask

  task automatic test_random;
    logic c = 0;
    cyc(0, 0, 1);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 24) == 0) c = ~c;
      cyc($urandom_range(0, 3) != 0, c, $urandom_range(0, 799) == 0);
      n_cmp += 3;
      if (bi.grid !== m_grid) begin n_bad++; $display("FAIL rand_grid@%0d: got %h want %h", n, bi.grid, m_grid); end
      if (bi.barrier !== m_grid[7]) begin n_bad++; $display("FAIL rand_barrier@%0d: got %h want %h", n, bi.barrier, m_grid[7]); end
      if (bi.spawn !== m_spawn) begin n_bad++; $display("FAIL rand_spawn@%0d: got %b want %b", n, bi.spawn, m_spawn); end
    end
  endtask

  initial begin
    test_reset;
    test_first_barrier;
    test_crash;
    test_gap_wrap;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
